// File: rtl/axi_write_firewall.sv
// axi_write_firewall
//   Write-side firewall between the NoC slave write port and a protected
//   memory target. Each AW is latched and shown to the address-permission
//   unit (APU). The APU answers combinationally. Permitted bursts are
//   forwarded on the M_ side. Write-protected bursts are drained locally,
//   answered with SLVERR, counted, and flagged on a sticky interrupt.
//   Only one write is outstanding at a time.
//
// Ports
//   ACLK, ARESET                  clock, async active-high reset
//   S_AW*/S_W*/S_B*               slave-side AXI4 write channels (from NoC)
//   M_AW*/M_W*/M_B*               master-side AXI4 write channels (to target)
//   APU_ADDR / APU_PERM           address under check / permission (10 = WP)
//   IS_VALID_ACCESS               1-cycle pulse when a checked write is allowed
//   VIOLATION_IRQ / IRQ_CLR       sticky violation flag and its clear
//   VIOLATION_CNT                 saturating count of blocked writes
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for AW, S_AWREADY high
// CHECK   | one cycle, APU_PERM sampled for the latched address
// FWD_AW  | presenting the latched AW to the target
// FWD_W   | W beats passed through, WLAST from the internal beat counter
// FWD_B   | target response passed back to the NoC
// DRAIN_W | protected burst, W beats accepted and discarded
// ERR_B   | SLVERR returned for the drained burst

module axi_write_firewall #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [31:0]       S_AWADDR,
  input  logic [7:0]        S_AWLEN,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  input  logic [DATA_W-1:0] S_WDATA,
  input  logic              S_WLAST,
  input  logic              S_WVALID,
  output logic              S_WREADY,
  output logic [1:0]        S_BRESP,
  output logic              S_BVALID,
  input  logic              S_BREADY,
  output logic [31:0]       M_AWADDR,
  output logic [7:0]        M_AWLEN,
  output logic              M_AWVALID,
  input  logic              M_AWREADY,
  output logic [DATA_W-1:0] M_WDATA,
  output logic              M_WLAST,
  output logic              M_WVALID,
  input  logic              M_WREADY,
  input  logic [1:0]        M_BRESP,
  input  logic              M_BVALID,
  output logic              M_BREADY,
  output logic [31:0]       APU_ADDR,
  input  logic [1:0]        APU_PERM,
  output logic              IS_VALID_ACCESS,
  output logic              VIOLATION_IRQ,
  input  logic              IRQ_CLR,
  output logic [CNT_W-1:0]  VIOLATION_CNT
);

  typedef enum logic [2:0] {
    IDLE, CHECK, FWD_AW, FWD_W, FWD_B, DRAIN_W, ERR_B
  } state_t;

  localparam logic [1:0] PERM_WP = 2'b10;
  localparam logic [1:0] SLVERR  = 2'b10;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_q, beat_d;
  logic               irq_q, irq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_set;
  logic               aw_ready_c;

  // The beat counter alone decides the end of a burst; S_WLAST is not trusted.
  logic unused_wlast;
  assign unused_wlast = S_WLAST;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beat_d          = beat_q;
    cnt_d           = cnt_q;
    irq_set         = 1'b0;
    aw_ready_c      = 1'b0;
    S_WREADY        = 1'b0;
    S_BRESP         = 2'b00;
    S_BVALID        = 1'b0;
    M_AWVALID       = 1'b0;
    M_WDATA         = '0;
    M_WLAST         = 1'b0;
    M_WVALID        = 1'b0;
    M_BREADY        = 1'b0;
    IS_VALID_ACCESS = 1'b0;

    case (state_q)
      IDLE: begin
        aw_ready_c = 1'b1;
        if (S_AWVALID) begin
          addr_d  = S_AWADDR;
          len_d   = S_AWLEN;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Only write protection blocks; read protection (01) is irrelevant here.
        if (APU_PERM == PERM_WP) begin
          irq_set = 1'b1;
          beat_d  = len_q;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          state_d = DRAIN_W;
        end else begin
          IS_VALID_ACCESS = 1'b1;
          state_d         = FWD_AW;
        end
      end
      FWD_AW: begin
        M_AWVALID = 1'b1;
        if (M_AWREADY) begin
          beat_d  = len_q;
          state_d = FWD_W;
        end
      end
      FWD_W: begin
        M_WVALID = S_WVALID;
        S_WREADY = M_WREADY;
        M_WDATA  = S_WDATA;
        M_WLAST  = (beat_q == 8'd0);
        if (S_WVALID && M_WREADY) begin
          if (beat_q == 8'd0) state_d = FWD_B;
          else                beat_d  = beat_q - 8'd1;
        end
      end
      FWD_B: begin
        S_BVALID = M_BVALID;
        S_BRESP  = M_BRESP;
        M_BREADY = S_BREADY;
        if (M_BVALID && S_BREADY) state_d = IDLE;
      end
      DRAIN_W: begin
        S_WREADY = 1'b1;
        if (S_WVALID) begin
          if (beat_q == 8'd0) state_d = ERR_B;
          else                beat_d  = beat_q - 8'd1;
        end
      end
      ERR_B: begin
        S_BVALID = 1'b1;
        S_BRESP  = SLVERR;
        if (S_BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new violation outranks a simultaneous clear.
    if (irq_set)      irq_d = 1'b1;
    else if (IRQ_CLR) irq_d = 1'b0;
    else              irq_d = irq_q;
  end

  // State is IDLE during reset, but every ready must still read low then.
  assign S_AWREADY     = aw_ready_c & ~ARESET;
  assign M_AWADDR      = addr_q;
  assign M_AWLEN       = len_q;
  assign APU_ADDR      = addr_q;
  assign VIOLATION_IRQ = irq_q;
  assign VIOLATION_CNT = cnt_q;

endmodule

// File: tb/tb_axi_write_firewall.sv
module tb_axi_write_firewall;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       s_awaddr;
  logic [7:0]        s_awlen;
  logic              s_awvalid;
  logic              s_awready;
  logic [DATA_W-1:0] s_wdata;
  logic              s_wlast;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [31:0]       m_awaddr;
  logic [7:0]        m_awlen;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wlast;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [31:0]       apu_addr;
  logic [1:0]        apu_perm;
  logic              is_valid;
  logic              irq;
  logic              irq_clr;
  logic [CNT_W-1:0]  vcnt;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_pulses = 0;
  int m_beats    = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_irq = 1'b0;

  always #5 clk = ~clk;

  axi_write_firewall #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
    .S_WDATA(s_wdata), .S_WLAST(s_wlast), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
    .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
    .M_AWADDR(m_awaddr), .M_AWLEN(m_awlen), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
    .M_WDATA(m_wdata), .M_WLAST(m_wlast), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
    .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
    .APU_ADDR(apu_addr), .APU_PERM(apu_perm), .IS_VALID_ACCESS(is_valid),
    .VIOLATION_IRQ(irq), .IRQ_CLR(irq_clr), .VIOLATION_CNT(vcnt)
  );

  always @(posedge clk) begin
    if (is_valid) vld_pulses++;
    if (m_wvalid && m_wready) m_beats++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] beat_data(input logic [31:0] a, input int b);
    return a ^ (32'hC0DE_0000 + 32'(b) * 32'h11);
  endfunction

  // Leaves the DUT in CHECK at a negedge.
  task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic clr_in_check);
    @(negedge clk);
    s_awaddr = a; s_awlen = l; s_awvalid = 1'b1;
    #1;
    chk("aw_ready_idle", s_awready, 1'b1);
    @(negedge clk);
    s_awvalid = 1'b0; s_awaddr = 32'hDEAD_BEEF; s_awlen = 8'hFF;
    irq_clr = clr_in_check;
    #1;
    chk("apu_addr", apu_addr, a);
    chk("valid_pulse", is_valid, apu_perm != 2'b10);
    chk("aw_ready_check", s_awready, 1'b0);
    chk("m_awvalid_check", m_awvalid, 1'b0);
  endtask

  task automatic fwd_aw(input logic [31:0] a, input logic [7:0] l, input int stall);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      m_awready = (i == stall);
      #1;
      chk("m_awvalid", m_awvalid, 1'b1);
      chk("m_awaddr", m_awaddr, a);
      chk("m_awlen", m_awlen, l);
      chk("aw_ready_fwd", s_awready, 1'b0);
    end
    @(negedge clk);
    m_awready = 1'b0;
  endtask

  // Presents beats until 'stop' beats are accepted; bp toggles M_WREADY.
  task automatic fwd_w(input logic [31:0] a, input logic [7:0] l, input int stop,
                       input logic bp, input logic wlast_bad);
    int b = 0;
    int cyc = 0;
    while (b < stop) begin
      if (cyc > 40) begin
        chk("w_timeout", 1'b0, 1'b1);
        break;
      end
      if (cyc > 0) @(negedge clk);
      s_wvalid = 1'b1;
      s_wdata  = beat_data(a, b);
      s_wlast  = wlast_bad ? 1'b0 : (b == int'(l));
      m_wready = bp ? cyc[0] : 1'b1;
      #1;
      chk("m_wvalid", m_wvalid, 1'b1);
      chk("m_wdata", m_wdata, beat_data(a, b));
      chk("m_wlast", m_wlast, b == int'(l));
      chk("s_wready_pass", s_wready, m_wready);
      if (m_wready) b++;
      cyc++;
    end
  endtask

  task automatic fwd_b(input logic [1:0] resp, input int stall);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      s_wvalid = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1; m_bresp = resp; s_bready = (i == stall);
      #1;
      chk("s_bvalid_fwd", s_bvalid, 1'b1);
      chk("s_bresp_fwd", s_bresp, resp);
      chk("m_bready", m_bready, i == stall);
      chk("s_wready_b", s_wready, 1'b0);
    end
    @(negedge clk);
    m_bvalid = 1'b0; m_bresp = 2'b00; s_bready = 1'b0;
    #1;
    chk("back_idle", s_awready, 1'b1);
    chk("s_bvalid_idle", s_bvalid, 1'b0);
  endtask

  task automatic drain(input logic [7:0] l, input int b_stall);
    for (int b = 0; b <= int'(l); b++) begin
      @(negedge clk);
      irq_clr = 1'b0;
      s_wvalid = 1'b1; s_wdata = 32'hBAD0_0000 + 32'(b); m_wready = 1'b1;
      #1;
      chk("drain_wready", s_wready, 1'b1);
      chk("drain_m_wvalid", m_wvalid, 1'b0);
      chk("drain_m_awvalid", m_awvalid, 1'b0);
    end
    for (int i = 0; i <= b_stall; i++) begin
      @(negedge clk);
      s_wvalid = 1'b0; m_wready = 1'b0; s_bready = (i == b_stall);
      #1;
      chk("err_bvalid", s_bvalid, 1'b1);
      chk("err_bresp", s_bresp, 2'b10);
      chk("err_wready", s_wready, 1'b0);
      chk("vcnt", vcnt, exp_cnt);
      chk("irq", irq, exp_irq);
    end
    @(negedge clk);
    s_bready = 1'b0;
    #1;
    chk("err_bresp_clear", s_bresp, 2'b00);
    chk("err_idle", s_awready, 1'b1);
  endtask

  task automatic protected_write(input logic [31:0] a, input logic [7:0] l,
                                 input logic clr_in_check);
    apu_perm = 2'b10;
    do_aw(a, l, clr_in_check);
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    exp_irq = 1'b1;
    drain(l, 1);
  endtask

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    apu_perm = 2'b00; irq_clr = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", s_awready, 1'b0);
    chk("rst_m_awaddr", m_awaddr, 32'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cnt", vcnt, 2'd0);
    chk("rst_bvalid", s_bvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", s_awready, 1'b1);

    // Open write, 4 beats.
    vld_pulses = 0; m_beats = 0;
    apu_perm = 2'b00;
    do_aw(32'h0000_1000, 8'd3, 1'b0);
    fwd_aw(32'h0000_1000, 8'd3, 0);
    fwd_w(32'h0000_1000, 8'd3, 4, 1'b0, 1'b0);
    fwd_b(2'b00, 0);
    chk("open_pulses", vld_pulses, 1);
    chk("open_beats", m_beats, 4);
    chk("open_cnt", vcnt, exp_cnt);

    // Protected write, 2 beats drained.
    m_beats = 0;
    protected_write(32'h0000_8000, 8'd1, 1'b0);
    chk("prot_no_fwd", m_beats, 0);
    chk("prot_cnt", vcnt, 2'd1);

    // Read-protected region: forwarded, S_WLAST deliberately wrong.
    m_beats = 0;
    apu_perm = 2'b01;
    do_aw(32'h0000_4004, 8'd0, 1'b0);
    fwd_aw(32'h0000_4004, 8'd0, 0);
    fwd_w(32'h0000_4004, 8'd0, 1, 1'b0, 1'b1);
    fwd_b(2'b01, 0);
    chk("rp_beats", m_beats, 1);
    chk("rp_cnt", vcnt, 2'd1);

    // Backpressure on all three channels.
    m_beats = 0;
    apu_perm = 2'b00;
    do_aw(32'h1234_5670, 8'd5, 1'b0);
    fwd_aw(32'h1234_5670, 8'd5, 5);
    fwd_w(32'h1234_5670, 8'd5, 6, 1'b1, 1'b0);
    fwd_b(2'b00, 3);
    chk("bp_beats", m_beats, 6);

    // IRQ clear on its own, then saturation.
    @(negedge clk); irq_clr = 1'b1;
    @(negedge clk); irq_clr = 1'b0; exp_irq = 1'b0;
    #1;
    chk("irq_clr", irq, 1'b0);
    chk("irq_clr_cnt", vcnt, 2'd1);
    for (int k = 0; k < 5; k++)
      protected_write(32'h0000_8000 + 32'(k) * 32'h40, 8'(k % 3), k == 4);
    chk("sat_cnt", vcnt, 2'd3);
    chk("set_wins", irq, 1'b1);
    @(negedge clk); irq_clr = 1'b1;
    @(negedge clk); irq_clr = 1'b0; exp_irq = 1'b0;
    #1;
    chk("irq_clr2", irq, 1'b0);
    chk("cnt_kept", vcnt, 2'd3);

    // Reset during beat 2 of an 8-beat forwarded burst.
    apu_perm = 2'b00;
    do_aw(32'h0000_2000, 8'd7, 1'b0);
    fwd_aw(32'h0000_2000, 8'd7, 0);
    fwd_w(32'h0000_2000, 8'd7, 1, 1'b0, 1'b0);
    @(negedge clk);
    s_wvalid = 1'b1; s_wdata = beat_data(32'h0000_2000, 1); m_wready = 1'b1;
    m_bvalid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_m_wvalid", m_wvalid, 1'b0);
    chk("mid_rst_s_wready", s_wready, 1'b0);
    chk("mid_rst_m_wdata", m_wdata, 32'h0);
    chk("mid_rst_awready", s_awready, 1'b0);
    chk("mid_rst_bvalid", s_bvalid, 1'b0);
    chk("mid_rst_bready", m_bready, 1'b0);
    chk("mid_rst_awaddr", m_awaddr, 32'h0);
    chk("mid_rst_awlen", m_awlen, 8'h0);
    chk("mid_rst_apu", apu_addr, 32'h0);
    chk("mid_rst_cnt", vcnt, 2'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0; s_wvalid = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;

    m_beats = 0;
    do_aw(32'h0000_3000, 8'd1, 1'b0);
    fwd_aw(32'h0000_3000, 8'd1, 0);
    fwd_w(32'h0000_3000, 8'd1, 2, 1'b0, 1'b0);
    fwd_b(2'b00, 0);
    chk("after_rst_beats", m_beats, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/axi_write_firewall.md
Name: axi_write_firewall

Overview:
- Sits between the NoC slave-side write port and the protected memory target.
- Latches each incoming AXI4 write address and presents it to the address-permission unit on APU_ADDR. The unit returns APU_PERM combinationally.
- Permitted writes (APU_PERM != 2'b10) are forwarded on the M_ side.
- Write-protected bursts are absorbed locally: W beats are drained and SLVERR is returned. Violations are counted and raise a sticky interrupt.

Parameters:
DATA_W, 32, W-channel data width
CNT_W, 8, violation counter width

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
S_AWADDR  in  32  write address from NoC
S_AWLEN  in  8  burst length minus one
S_AWVALID  in  1  AW valid
S_AWREADY  out  1  AW ready
S_WDATA  in  DATA_W  write data
S_WLAST  in  1  last beat marker
S_WVALID  in  1  W valid
S_WREADY  out  1  W ready
S_BRESP  out  2  write response
S_BVALID  out  1  B valid
S_BREADY  in  1  B ready
M_AWADDR  out  32  forwarded address
M_AWLEN  out  8  forwarded length
M_AWVALID  out  1  forwarded AW valid
M_AWREADY  in  1  target AW ready
M_WDATA  out  DATA_W  forwarded data
M_WLAST  out  1  forwarded last
M_WVALID  out  1  forwarded W valid
M_WREADY  in  1  target W ready
M_BRESP  in  2  target response
M_BVALID  in  1  target B valid
M_BREADY  out  1  target B ready
APU_ADDR  out  32  address under check (to permission unit)
APU_PERM  in  2  00 open, 01 read-protected, 10 write-protected
IS_VALID_ACCESS  out  1  1-cycle pulse: checked write permitted
VIOLATION_IRQ  out  1  sticky violation interrupt
IRQ_CLR  in  1  clears VIOLATION_IRQ
VIOLATION_CNT  out  CNT_W  saturating count of blocked writes

Behaviour:
- One outstanding write at a time.
- FSM states: IDLE, CHECK, FWD_AW, FWD_W, FWD_B, DRAIN_W, ERR_B.
- Reset (async, ARESET=1):
  - state=IDLE.
  - All VALID/READY outputs 0; IS_VALID_ACCESS=0; VIOLATION_IRQ=0; VIOLATION_CNT=0.
  - addr/len registers, APU_ADDR, S_BRESP, M_AWADDR, M_AWLEN and M_WDATA all 0.
  - Asserting reset mid-burst abandons the transaction with no B response.
- IDLE:
  - S_AWREADY=1.
  - On S_AWVALID, latch S_AWADDR into addr_q (drives APU_ADDR and M_AWADDR) and S_AWLEN into len_q (drives M_AWLEN); go to CHECK.
- CHECK (exactly 1 cycle): sample APU_PERM.
  - 2'b10: go to DRAIN_W; increment VIOLATION_CNT (saturate at all-ones); set VIOLATION_IRQ.
  - Otherwise: pulse IS_VALID_ACCESS for this cycle; go to FWD_AW.
  - 01 is a read restriction and does not block writes.
  - AW acceptance to M_AWVALID is 2 cycles.
- FWD_AW:
  - M_AWVALID=1 and held stable until M_AWREADY.
  - Then go to FWD_W and load beat counter = len_q.
- FWD_W:
  - Combinational pass-through: M_WVALID=S_WVALID, S_WREADY=M_WREADY, M_WDATA=S_WDATA.
  - M_WLAST is generated internally, asserted when beat counter == 0.
  - Decrement the counter on each M_WVALID&M_WREADY. After the beat with counter 0, go to FWD_B.
  - An S_WLAST mismatch is ignored; the counter is authoritative.
- FWD_B:
  - Pass-through: S_BVALID=M_BVALID, S_BRESP=M_BRESP, M_BREADY=S_BREADY.
  - On handshake, go to IDLE.
- DRAIN_W:
  - S_WREADY=1; M_WVALID stays 0; beat counter loaded with len_q.
  - Decrement on each S_WVALID beat. After len_q+1 beats, go to ERR_B.
- ERR_B:
  - S_BVALID=1, S_BRESP=2'b10 (SLVERR), held until S_BREADY.
  - Then go to IDLE; S_BRESP returns to 00.
- IRQ/counter:
  - IRQ_CLR=1 clears VIOLATION_IRQ next cycle.
  - If a set and IRQ_CLR occur in the same cycle, set wins.
  - IRQ_CLR does not clear VIOLATION_CNT.
- Ready gating: S_AWREADY=0 in every state except IDLE. S_WREADY=0 outside FWD_W and DRAIN_W.
- M_AWVALID, M_WVALID and M_BREADY are 0 outside their own states.

Test Plan:
- Open write: AWADDR=0x0000_1000, PERM=00, AWLEN=3, 4 beats -> M_AWVALID 2 cycles after AW handshake; 4 beats forwarded, M_WLAST on beat 4; IS_VALID_ACCESS pulses once; target BRESP=00 returned.
- Protected write: PERM=10, AWLEN=1 -> no M_AWVALID and no M_WVALID; 2 beats drained; S_BRESP=10; VIOLATION_CNT=1; VIOLATION_IRQ=1.
- Read-protected region written: PERM=01, AWLEN=0 -> forwarded normally; counter unchanged.
- Backpressure: M_AWREADY low 5 cycles, M_WREADY toggling, S_BREADY low 3 cycles -> M_AWADDR stable; no beat lost or duplicated; B held until ready.
- Saturation/IRQ: CNT_W=2, 5 protected writes -> CNT=3. IRQ_CLR asserted in the same cycle as the 5th violation's CHECK -> IRQ stays 1. A later IRQ_CLR alone -> 0.
- Reset mid-burst: ARESET during beat 2 of an 8-beat forwarded burst -> all outputs at reset values immediately; next write processed cleanly.
